// File: rtl/fm_tune_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fm_tune_ctrl
//
// Station-tuning sequencer for the FM transmitter (25 MHz domain).
// Raw up/down buttons are synchronized and debounced. Each accepted press
// requests a one-channel step. Every retune runs the same sequence so the
// channel change is never audible:
//   fade PCM out -> step the carrier word -> hold muted while the synth
//   settles -> fade PCM back in.
//
// Optional feature (macro FM_TUNE_AUTOREPEAT_EN):
//   When defined, a held button auto-repeats. The first repeat comes after
//   REPEAT_DELAY cycles, and further repeats follow every REPEAT_CYCLES.
//   When undefined, the design makes one step per press and the repeat
//   logic is not built.
//
// Ports:
//   clk_25m   in   1          system clock, 25 MHz
//   reset_n   in   1          asynchronous active-low reset
//   btn_up    in   1          raw asynchronous button, one channel up
//   btn_down  in   1          raw asynchronous button, one channel down
//   pcm_in    in   16 signed  composite audio from the RDS mixer
//   pcm_out   out  16 signed  gain-scaled PCM to the FM generator (registered)
//   cw_freq   out  32         carrier frequency in Hz
//   chan      out  8          current channel index
//   busy      out  1          high while a retune sequence is in progress
// -----------------------------------------------------------------------------
module fm_tune_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FREQ_MIN        = 87500000,
    parameter int FREQ_STEP       = 100000,
    parameter int CHAN_MAX        = 206,
    parameter int CHAN_INIT       = 206,
    parameter int RAMP_CYCLES     = 1562,
    parameter int SETTLE_CYCLES   = 25000
) (
    input  logic               clk_25m,
    input  logic               reset_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic signed [15:0] pcm_in,
    output logic signed [15:0] pcm_out,
    output logic        [31:0] cw_freq,
    output logic        [7:0]  chan,
    output logic               busy
);

    localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RAMP_W   = $clog2(RAMP_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [31:0]       FREQ_LO   = 32'(FREQ_MIN);
    localparam logic [31:0]       FREQ_HI   = 32'(FREQ_MIN + CHAN_MAX * FREQ_STEP);
    localparam logic [31:0]       FREQ_INIT = 32'(FREQ_MIN + CHAN_INIT * FREQ_STEP);
    localparam logic [31:0]       FREQ_INC  = 32'(FREQ_STEP);
    localparam logic [7:0]        CHAN_TOP  = 8'(CHAN_MAX);
    localparam logic [7:0]        CHAN_RST  = 8'(CHAN_INIT);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FADE_OUT = 3'd1,
        ST_RETUNE   = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_FADE_IN  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    // Button path: index 0 = up, index 1 = down
    logic [1:0]       w_btn_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_stable;
    logic [1:0]       r_stable_d;
    logic [DEB_W-1:0] r_deb_cnt [2];
    logic [1:0]       w_edge;
    logic [1:0]       w_req;

    // Request latch and sequencer
    dir_t             r_pending;
    dir_t             w_new_dir;
    logic             w_new_valid;
    dir_t             r_dir;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_start;
    logic             w_done;
    logic             w_ramp_tick;
    logic             w_settle_done;

    logic [4:0]          r_gain;
    logic [RAMP_W-1:0]   r_ramp_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [7:0]          r_chan;
    logic [31:0]         r_freq;
    logic                r_busy;

    // Audio path
    logic signed [20:0] w_pcm_ext;
    logic signed [20:0] w_gain_ext;
    logic signed [20:0] w_prod;
    logic signed [15:0] r_pcm_out;

    assign w_btn_raw = {btn_down, btn_up};

    // Two-flop synchronizer for both raw buttons
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count while the synchronized level disagrees with the
    // stable level; any agreement in between restarts the count.
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            r_stable   <= 2'b00;
            r_stable_d <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_stable[i]  <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_edge = r_stable & ~r_stable_d;

`ifdef FM_TUNE_AUTOREPEAT_EN
    localparam int REPEAT_DELAY  = 12500000;
    localparam int REPEAT_CYCLES = 2500000;
    localparam int REP_W         = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] r_rep_cnt [2];
    logic [1:0]       r_rep_armed;
    logic [1:0]       r_rep_pulse;

    // Auto-repeat timer per button; release clears it so the next hold
    // starts with the long initial delay again.
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            r_rep_armed <= 2'b00;
            r_rep_pulse <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!r_stable[i]) begin
                    r_rep_cnt[i]   <= '0;
                    r_rep_armed[i] <= 1'b0;
                    r_rep_pulse[i] <= 1'b0;
                end else if (!r_rep_armed[i] && (r_rep_cnt[i] == REP_FIRST)) begin
                    r_rep_cnt[i]   <= '0;
                    r_rep_armed[i] <= 1'b1;
                    r_rep_pulse[i] <= 1'b1;
                end else if (r_rep_armed[i] && (r_rep_cnt[i] == REP_NEXT)) begin
                    r_rep_cnt[i]   <= '0;
                    r_rep_pulse[i] <= 1'b1;
                end else begin
                    r_rep_cnt[i]   <= r_rep_cnt[i] + 1'b1;
                    r_rep_pulse[i] <= 1'b0;
                end
            end
        end
    end

    assign w_req = w_edge | r_rep_pulse;
`else
    assign w_req = w_edge;
`endif

    // Decode this cycle's press pulses; up+down together cancel out
    always_comb begin
        w_new_dir   = DIR_NONE;
        w_new_valid = 1'b0;
        case (w_req)
            2'b01: begin
                w_new_dir   = DIR_UP;
                w_new_valid = 1'b1;
            end
            2'b10: begin
                w_new_dir   = DIR_DOWN;
                w_new_valid = 1'b1;
            end
            default: begin
                w_new_dir   = DIR_NONE;
                w_new_valid = 1'b0;
            end
        endcase
    end

    assign w_ramp_tick   = (r_ramp_cnt == RAMP_LAST);
    assign w_settle_done = (r_settle_cnt == SETTLE_LAST);

    // Sequencer state register
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != DIR_NONE) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FADE_OUT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FADE_OUT: begin
                // leave on the step that takes gain from 1 to 0
                if (w_ramp_tick && (r_gain <= 5'd1)) begin
                    w_state_nxt = ST_RETUNE;
                end else begin
                    w_state_nxt = ST_FADE_OUT;
                end
            end
            ST_RETUNE: begin
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    w_state_nxt = ST_FADE_IN;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_FADE_IN: begin
                if (w_ramp_tick && (r_gain >= 5'd15)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FADE_IN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch: a new press always wins, even in the cycle IDLE consumes
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= DIR_NONE;
            r_dir     <= DIR_NONE;
        end else begin
            if (w_new_valid) begin
                r_pending <= w_new_dir;
            end else if (w_start) begin
                r_pending <= DIR_NONE;
            end else begin
                r_pending <= r_pending;
            end
            if (w_start) begin
                r_dir <= r_pending;
            end else begin
                r_dir <= r_dir;
            end
        end
    end

    // Gain ramp, settle timer and busy flag
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            r_gain       <= 5'd16;
            r_ramp_cnt   <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b0;
        end else begin
            if ((r_state == ST_FADE_OUT) || (r_state == ST_FADE_IN)) begin
                if (w_ramp_tick) begin
                    r_ramp_cnt <= '0;
                    if (r_state == ST_FADE_OUT) begin
                        r_gain <= r_gain - 5'd1;
                    end else begin
                        r_gain <= r_gain + 5'd1;
                    end
                end else begin
                    r_ramp_cnt <= r_ramp_cnt + 1'b1;
                end
            end else begin
                r_ramp_cnt <= '0;
            end

            if ((r_state == ST_SETTLE) && !w_settle_done) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end

            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_done) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

    // Channel and carrier word: stepped by accumulation, reloaded on wrap
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            r_chan <= CHAN_RST;
            r_freq <= FREQ_INIT;
        end else if (r_state == ST_RETUNE) begin
            case (r_dir)
                DIR_UP: begin
                    if (r_chan >= CHAN_TOP) begin
                        r_chan <= 8'd0;
                        r_freq <= FREQ_LO;
                    end else begin
                        r_chan <= r_chan + 8'd1;
                        r_freq <= r_freq + FREQ_INC;
                    end
                end
                DIR_DOWN: begin
                    if (r_chan == 8'd0) begin
                        r_chan <= CHAN_TOP;
                        r_freq <= FREQ_HI;
                    end else begin
                        r_chan <= r_chan - 8'd1;
                        r_freq <= r_freq - FREQ_INC;
                    end
                end
                default: begin
                    r_chan <= r_chan;
                    r_freq <= r_freq;
                end
            endcase
        end else begin
            r_chan <= r_chan;
            r_freq <= r_freq;
        end
    end

    // 21 bits hold pcm_in * 16 exactly, so gain 16 is a true pass-through
    assign w_pcm_ext  = {{5{pcm_in[15]}}, pcm_in};
    assign w_gain_ext = $signed({16'd0, r_gain});
    assign w_prod     = w_pcm_ext * w_gain_ext;

    // Registered gain-scaled PCM output
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            r_pcm_out <= 16'sd0;
        end else begin
            r_pcm_out <= 16'(w_prod >>> 4);
        end
    end

    assign pcm_out = r_pcm_out;
    assign cw_freq = r_freq;
    assign chan    = r_chan;
    assign busy    = r_busy;

endmodule
